// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the dmux_stream demultiplexer.
package dmux_pkg;

  localparam int DROP_CNT_W = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

  // A two-way demux still needs a one-bit select.
  function automatic int sel_width(input int m);
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry output register with a valid/ready handshake toward one consumer lane.
module dmux_slot #(
  parameter int N = 98
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] data,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] q,
  output logic         free
);

  // Free also when the current word leaves this cycle, so a lane sustains one word per clock.
  assign free = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-M streaming demultiplexer with unicast/broadcast routing and
// a saturating counter of words dropped for an out-of-range select.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter  int N  = 98,
  parameter  int M  = 4,
  localparam int SW = sel_width(M)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N-1:0]          IN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [SW-1:0]         SEL,
  input  logic                  BCAST,
  output logic [M*N-1:0]        OUT,
  output logic [M-1:0]          OUT_VALID,
  input  logic [M-1:0]          OUT_READY,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  logic [M-1:0]          free;
  logic [M-1:0]          sel_hit;
  logic [M-1:0]          load;
  logic                  in_range;
  logic                  accept;
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < M; k++) begin
      if (SEL == SW'(k)) sel_hit[k] = 1'b1;
    end
  end

  // An empty sel_hit means SEL names no channel; such words are always taken and discarded.
  assign in_range = |sel_hit;
  assign IN_READY = BCAST ? &free : (in_range ? |(sel_hit & free) : 1'b1);
  assign accept   = IN_VALID && IN_READY;
  assign load     = accept ? (BCAST ? {M{1'b1}} : sel_hit) : {M{1'b0}};
  assign drop     = accept && !BCAST && !in_range;

  for (genvar k = 0; k < M; k++) begin : g_slot
    dmux_slot #(.N(N)) u_slot (
      .clk   (CLK),
      .rst   (RST),
      .load  (load[k]),
      .data  (IN),
      .ready (OUT_READY[k]),
      .valid (OUT_VALID[k]),
      .q     (OUT[k*N +: N]),
      .free  (free[k])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: a 4-channel instance driven from a vector table and
// hand sequences, and a 3-channel instance under random traffic vs a queue model.
module tb_dmux_stream;

  localparam int N  = 98;
  localparam int M4 = 4;
  localparam int M3 = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     sel;
  logic           bcast;
  logic [M4*N-1:0] out_bus;
  logic [M4-1:0]  out_valid;
  logic [M4-1:0]  out_ready;
  logic [15:0]    drop_cnt;

  logic [N-1:0]   in3_data;
  logic           in3_valid;
  logic           in3_ready;
  logic [1:0]     sel3;
  logic           bcast3;
  logic [M3*N-1:0] out3_bus;
  logic [M3-1:0]  out3_valid;
  logic [M3-1:0]  out3_ready;
  logic [15:0]    drop3_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmux_stream #(.N(N), .M(M4)) dut (
    .CLK(clk), .RST(rst), .IN(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .SEL(sel), .BCAST(bcast), .OUT(out_bus), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .DROP_CNT(drop_cnt)
  );

  dmux_stream #(.N(N), .M(M3)) dut3 (
    .CLK(clk), .RST(rst), .IN(in3_data), .IN_VALID(in3_valid), .IN_READY(in3_ready),
    .SEL(sel3), .BCAST(bcast3), .OUT(out3_bus), .OUT_VALID(out3_valid),
    .OUT_READY(out3_ready), .DROP_CNT(drop3_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          v;
    logic [N-1:0]  d;
    logic [1:0]    sel;
    logic          bc;
    logic [3:0]    ordy;
    logic          exp_rdy;
    logic [3:0]    exp_vld;
    int            sidx;
    logic [N-1:0]  sdat;
  } vec_t;

  function automatic vec_t mk(input logic v, input int d, input int s, input logic bc,
                              input logic [3:0] ordy, input logic exp_rdy,
                              input logic [3:0] exp_vld, input int sidx, input int sdat);
    vec_t r;
    r.v = v; r.d = N'(d); r.sel = 2'(s); r.bc = bc; r.ordy = ordy;
    r.exp_rdy = exp_rdy; r.exp_vld = exp_vld; r.sidx = sidx; r.sdat = N'(sdat);
    return r;
  endfunction

  vec_t tbl[11];

  logic [N-1:0] sb[M3][$];
  logic [15:0]  mdl_drop;

  initial begin
    // single unicast, then drain
    tbl[0]  = mk(1, 4532, 2, 0, 4'b1111, 1, 4'b0100, 2, 4532);
    tbl[1]  = mk(0, 0,    0, 0, 4'b1111, 1, 4'b0000, 2, 4532);
    // back-pressure on channel 1
    tbl[2]  = mk(1, 4532, 1, 0, 4'b1101, 1, 4'b0010, 1, 4532);
    tbl[3]  = mk(1, 4533, 1, 0, 4'b1101, 0, 4'b0010, 1, 4532);
    tbl[4]  = mk(1, 4533, 1, 0, 4'b1111, 1, 4'b0010, 1, 4533);
    tbl[5]  = mk(0, 0,    0, 0, 4'b1111, 1, 4'b0000, 1, 4533);
    // broadcast blocked by a stalled full slot 3
    tbl[6]  = mk(1, 7,    3, 0, 4'b0111, 1, 4'b1000, 3, 7);
    tbl[7]  = mk(1, 4532, 0, 1, 4'b0111, 0, 4'b1000, 0, 0);
    tbl[8]  = mk(1, 4532, 0, 1, 4'b1111, 1, 4'b1111, 3, 4532);
    tbl[9]  = mk(0, 0,    0, 0, 4'b0000, 0, 4'b1111, 0, 4532);
    tbl[10] = mk(0, 0,    0, 0, 4'b1111, 1, 4'b0000, 2, 4532);

    rst = 1'b1;
    in_data = '0; in_valid = 0; sel = 0; bcast = 0; out_ready = '1;
    in3_data = '0; in3_valid = 0; sel3 = 0; bcast3 = 0; out3_ready = '1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_bus", 128'(out_bus[N-1:0] | out_bus[3*N +: N]), 128'(0));
    chk("reset_drop_cnt", 128'(drop_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = tbl[i].v; in_data = tbl[i].d; sel = tbl[i].sel;
      bcast = tbl[i].bc; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 128'(out_valid), 128'(tbl[i].exp_vld));
      chk($sformatf("tbl%0d_slice%0d", i, tbl[i].sidx),
          128'(out_bus[tbl[i].sidx*N +: N]), 128'(tbl[i].sdat));
    end

    // sustained stream into channel 0
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1; in_data = N'(i); sel = 0; bcast = 0; out_ready = '1;
      #1;
      chk($sformatf("stream%0d_in_ready", i), 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_slice0", i), 128'(out_bus[0 +: N]), 128'(i));
      chk($sformatf("stream%0d_valid0", i), 128'(out_valid[0]), 128'(1));
    end
    @(negedge clk);
    in_valid = 0;

    // out-of-range select on the 3-channel instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in3_valid = 1; sel3 = 2'd3; bcast3 = 0; in3_data = N'(100 + i); out3_ready = '0;
      #1;
      chk($sformatf("drop%0d_in_ready", i), 128'(in3_ready), 128'(1));
      @(posedge clk);
    end
    @(negedge clk);
    in3_valid = 0;
    chk("drop_out_valid", 128'(out3_valid), 128'(0));
    chk("drop_cnt_5", 128'(drop3_cnt), 128'(5));

    force dut3.drop_cnt_q = 16'hFFFE;
    #1;
    release dut3.drop_cnt_q;
    #1;
    chk("drop_preload", 128'(drop3_cnt), 128'(16'hFFFE));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in3_valid = 1; sel3 = 2'd3;
      @(posedge clk);
      #1;
      chk($sformatf("drop_sat%0d", i), 128'(drop3_cnt), 128'(16'hFFFF));
    end
    @(negedge clk);
    in3_valid = 0;

    // async reset with slots 0 and 2 holding data
    in_valid = 1; sel = 0; in_data = N'(11); out_ready = '0;
    @(negedge clk);
    sel = 2; in_data = N'(22);
    @(negedge clk);
    in_valid = 0;
    chk("pre_reset_valid", 128'(out_valid), 128'(4'b0101));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_valid", 128'(out_valid), 128'(0));
    chk("async_reset_slice0", 128'(out_bus[0 +: N]), 128'(0));
    chk("async_reset_drop3", 128'(drop3_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1; sel = 1; in_data = N'(33); out_ready = '1;
    @(posedge clk);
    #1;
    chk("post_reset_valid", 128'(out_valid), 128'(4'b0010));
    chk("post_reset_slice1", 128'(out_bus[N +: N]), 128'(33));
    @(negedge clk);
    in_valid = 0;

    // random traffic on the 3-channel instance, checked against per-channel queues
    mdl_drop = 16'd0;
    for (int c = 0; c < 400; c++) begin
      logic [M3-1:0] fr;
      logic          exp_rdy;
      bit            in_rng;
      @(negedge clk);
      for (int k = 0; k < M3; k++) begin
        chk($sformatf("rnd%0d_valid%0d", c, k), 128'(out3_valid[k]), 128'(sb[k].size() != 0));
        if (sb[k].size() != 0)
          chk($sformatf("rnd%0d_data%0d", c, k), 128'(out3_bus[k*N +: N]), 128'(sb[k][0]));
      end
      chk($sformatf("rnd%0d_drop", c), 128'(drop3_cnt), 128'(mdl_drop));

      in3_valid  = ($urandom_range(3) != 0);
      sel3       = 2'($urandom_range(3));
      bcast3     = ($urandom_range(7) == 0);
      out3_ready = 3'($urandom);
      in3_data   = N'({$urandom, $urandom, $urandom, $urandom});
      #1;
      for (int k = 0; k < M3; k++) fr[k] = (sb[k].size() == 0) || out3_ready[k];
      in_rng = (int'(sel3) < M3);
      if (bcast3) exp_rdy = &fr;
      else if (in_rng) exp_rdy = fr[sel3];
      else exp_rdy = 1'b1;
      chk($sformatf("rnd%0d_in_ready", c), 128'(in3_ready), 128'(exp_rdy));

      for (int k = 0; k < M3; k++)
        if (sb[k].size() != 0 && out3_ready[k]) void'(sb[k].pop_front());
      if (in3_valid && exp_rdy) begin
        if (bcast3) begin
          for (int k = 0; k < M3; k++) sb[k].push_back(in3_data);
        end else if (in_rng) begin
          sb[sel3].push_back(in3_data);
        end else if (mdl_drop != 16'hFFFF) begin
          mdl_drop = mdl_drop + 16'd1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
Parametrised, registered 1-to-M streaming demultiplexer; the successor to the fixed 4-way combinational DMUXS.
- Routes an N-bit word to one of M outputs (unicast) or to all outputs (broadcast).
- Each output has a one-entry output register and a valid/ready handshake, so back-pressure is handled without data loss.
- Sits between the FPTD datapath stage producer and M parallel consumer lanes.

Parameters:
N, 98, data word width in bits
M, 4, number of output channels (2..16, need not be a power of 2)
SW, $clog2(M), select width (derived; not overridden)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
IN  in  N  input data word
IN_VALID  in  1  input word present
IN_READY  out  1  block accepts input this cycle
SEL  in  SW  unicast destination channel, sampled with the input word
BCAST  in  1  1 = write word to all M channels, SEL ignored
OUT  out  M*N  flattened outputs; channel k occupies bits [k*N +: N]
OUT_VALID  out  M  per-channel output valid
OUT_READY  in  M  per-channel consumer ready
DROP_CNT  out  16  count of words dropped for out-of-range SEL, saturating

Behaviour:
- Reset (async assert, sync release):
  - OUT_VALID = 0, all OUT slices = 0, DROP_CNT = 0.
  - Buffered words are discarded; reset mid-transfer loses them by design.
- Handshake rules:
  - Input accept = IN_VALID && IN_READY.
  - Channel k transfer = OUT_VALID[k] && OUT_READY[k].
- Slot k is "free" when OUT_VALID[k] = 0, or when OUT_READY[k] = 1 in the same cycle (drain-and-refill).
- IN_READY (combinational from OUT_VALID, OUT_READY, SEL, BCAST):
  - Unicast, SEL < M: IN_READY = free[SEL].
  - Broadcast: IN_READY = AND of free[0..M-1].
  - Unicast, SEL >= M: IN_READY = 1.
- On accept, unicast in range:
  - OUT slice SEL <= IN and OUT_VALID[SEL] <= 1 on the next edge; latency 1 cycle.
  - All other channels are unchanged.
- On accept, broadcast: every slice <= IN and every OUT_VALID <= 1 on the same edge.
- On accept with SEL >= M, unicast: word is consumed and discarded, and DROP_CNT increments. It holds at 16'hFFFF.
- Channel k transfer with no new load into k: OUT_VALID[k] <= 0 on the next edge; OUT slice k keeps its last value.
- Simultaneous drain and load of the same channel: OUT_VALID[k] stays 1 and the data is replaced. This gives one word per cycle sustained per channel.
- Stability: while OUT_VALID[k] = 1 and OUT_READY[k] = 0, OUT slice k and OUT_VALID[k] must not change.
- No combinational path from IN to OUT; OUT is fully registered.
- SEL and BCAST are don't-care when IN_VALID = 0.

Decomposition:
- Package dmux_pkg holds:
  - DROP_CNT_W = 16 and DROP_CNT_MAX.
  - A sel_width(M) function returning max(1, $clog2(M)).
- Sub-module dmux_slot: a one-entry N-bit register with load, valid/ready and a free output.
  - Instantiated M times by a generate loop.
  - The top level holds the IN_READY logic, broadcast/unicast decode and the drop counter.

Test Plan:
1. N=98, M=4, all OUT_READY=1; IN=4532, SEL=2, BCAST=0, one cycle -> OUT_VALID=4'b0100 one cycle later, slice 2 = 4532, others 0, IN_READY stays 1.
2. OUT_READY[1]=0; two words 4532 then 4533 to SEL=1 -> first accepted, IN_READY=0 while second waits, slice 1 holds 4532. Raise OUT_READY[1] -> 4532 consumed, 4533 appears the next cycle, no loss or duplication.
3. BCAST=1, IN=4532 with slot 3 full and OUT_READY[3]=0 -> IN_READY=0, no slot changes. Raise OUT_READY[3] -> same edge loads 4532 in all four slots, OUT_VALID=4'b1111.
4. M=3 instance, SEL=3, IN_VALID=1 for 5 cycles -> IN_READY=1, OUT_VALID stays 3'b000, DROP_CNT=5. Preload 16'hFFFF and drop once more -> DROP_CNT stays 16'hFFFF.
5. Continuous stream 0,1,2,... to SEL=0 with OUT_READY[0]=1 -> one word per cycle on slice 0, in order, 1-cycle latency, IN_READY never drops.
6. Slots 0 and 2 full, assert RST between clock edges -> OUT_VALID=0 and DROP_CNT=0 immediately, without a clock edge. After release, the first accepted word appears normally.
